goc_rx: RTL and testbench

- Receive-side counterpart of the GOC PWM transmitter.
- Samples the GOC optical input pad, removes polarity, measures the high and low times of each PWM bit, and rebuilds bytes MSB-first.
- Presents the bytes as a framed byte stream to a bus_interface / ICE message path; an idle line marks the end of a frame.

---
 rtl/goc_rx_pkg.sv | 16 +
 rtl/goc_rx_if.sv | 26 ++
 rtl/goc_edge_sync.sv | 35 +++
 rtl/goc_rx.sv | 195 +++++++++++++++++++
 tb/tb_goc_rx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/goc_rx_pkg.sv
// Shared definitions for the GOC receive path: state encodings and default sizes.
package goc_rx_pkg;

    localparam int GOC_CNT_W       = 22;
    localparam int GOC_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HIGH      = 3'd1,
        ST_LOW       = 3'd2,
        ST_END       = 3'd3,
        ST_ABORT     = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } goc_rx_state_e;

endpackage

// File: rtl/goc_rx_if.sv
// Framed byte stream from the GOC receiver towards the bus_interface / ICE message path.
interface goc_rx_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_valid;
    logic       rx_frame_done;
    logic       rx_frame_err;

    modport master (
        output rx_data,
        output rx_data_valid,
        output rx_frame_valid,
        output rx_frame_done,
        output rx_frame_err
    );

    modport slave (
        input rx_data,
        input rx_data_valid,
        input rx_frame_valid,
        input rx_frame_done,
        input rx_frame_err
    );

endinterface

// File: rtl/goc_edge_sync.sv
// Metastability synchroniser for an asynchronous GOC pad, polarity removal and
// registered rise/fall strobes aligned with the registered line level.
module goc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    input  logic polarity,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;

    assign line = sync_q[SYNC_STAGES-1] ^ polarity;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            level  <= line;
            rise   <= line & ~level;
            fall   <= ~line & level;
        end
    end

endmodule

// File: rtl/goc_rx.sv
// GOC PWM receiver: measures high/low time of each bit, rebuilds bytes MSB-first and
// frames them, with an idle-low line closing the frame.
module goc_rx
    import goc_rx_pkg::*;
#(
    parameter int CNT_W       = GOC_CNT_W,
    parameter int SYNC_STAGES = GOC_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             GOC_PAD_IN,
    input  logic             goc_polarity,
    input  logic [CNT_W-1:0] goc_timeout,
    input  logic [CNT_W-1:0] goc_min_pulse,
    goc_rx_if.master         rx
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int               SETTLE_W = $clog2(SYNC_STAGES + 3);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);

    logic level, rise, fall;

    goc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .pad      (GOC_PAD_IN),
        .polarity (goc_polarity),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    goc_rx_state_e       state;
    logic [CNT_W-1:0]    hi_cnt, lo_cnt;
    logic [CNT_W:0]      ref_period;
    logic [7:0]          shreg;
    logic [2:0]          bit_cnt;
    logic                have_period;
    logic                done_pend;
    logic [SETTLE_W-1:0] settle_cnt;

    logic [CNT_W-1:0] timeout_eff, hi_inc, lo_inc;
    logic [CNT_W:0]   period_sum;
    logic             glitch_hi, glitch_lo, settled;
    logic             rise_bit, end_bit;
    logic [7:0]       rise_byte, end_byte;

    assign timeout_eff = (goc_timeout == '0) ? CNT_ONE : goc_timeout;
    assign hi_inc      = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;
    assign lo_inc      = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + CNT_ONE;
    assign glitch_hi   = (goc_min_pulse != '0) && (hi_cnt < goc_min_pulse);
    assign glitch_lo   = (goc_min_pulse != '0) && (lo_cnt < goc_min_pulse);
    // Two saturated CNT_W counters always fit in CNT_W+1 bits, so the sum cannot wrap.
    assign period_sum  = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign rise_bit    = hi_cnt > lo_cnt;
    assign end_bit     = {hi_cnt, 1'b0} > ref_period;
    assign rise_byte   = {shreg[6:0], rise_bit};
    assign end_byte    = {shreg[6:0], end_bit};
    assign settled     = settle_cnt == SETTLE_MAX;

    // Covers the synchroniser fill after reset: a line seen high in this window was high at release.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            hi_cnt            <= '0;
            lo_cnt            <= '0;
            ref_period        <= '0;
            shreg             <= '0;
            bit_cnt           <= '0;
            have_period       <= 1'b0;
            done_pend         <= 1'b0;
            rx.rx_data        <= 8'h00;
            rx.rx_data_valid  <= 1'b0;
            rx.rx_frame_valid <= 1'b0;
            rx.rx_frame_done  <= 1'b0;
            rx.rx_frame_err   <= 1'b0;
        end else begin
            rx.rx_data_valid <= 1'b0;
            rx.rx_frame_done <= 1'b0;
            rx.rx_frame_err  <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (done_pend) begin
                        rx.rx_frame_done <= 1'b1;
                        done_pend        <= 1'b0;
                    end
                    if (!settled) begin
                        if (level || rise) begin
                            state  <= ST_WAIT_IDLE;
                            lo_cnt <= '0;
                        end
                    end else if (rise) begin
                        state             <= ST_HIGH;
                        rx.rx_frame_valid <= 1'b1;
                        hi_cnt            <= CNT_ONE;
                        lo_cnt            <= '0;
                        ref_period        <= '0;
                        have_period       <= 1'b0;
                        shreg             <= '0;
                        bit_cnt           <= '0;
                    end
                end

                ST_HIGH: begin
                    if (fall) begin
                        if (glitch_hi) begin
                            state <= ST_ABORT;
                        end else begin
                            state  <= ST_LOW;
                            lo_cnt <= CNT_ONE;
                        end
                    end else if (hi_cnt >= timeout_eff) begin
                        state <= ST_ABORT;
                    end else begin
                        hi_cnt <= hi_inc;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        if (glitch_lo) begin
                            state <= ST_ABORT;
                        end else begin
                            shreg       <= rise_byte;
                            bit_cnt     <= bit_cnt + 3'd1;
                            ref_period  <= period_sum;
                            have_period <= 1'b1;
                            hi_cnt      <= CNT_ONE;
                            lo_cnt      <= '0;
                            state       <= ST_HIGH;
                            if (bit_cnt == 3'd7) begin
                                rx.rx_data       <= rise_byte;
                                rx.rx_data_valid <= 1'b1;
                            end
                        end
                    end else if (lo_cnt >= timeout_eff) begin
                        state <= ST_END;
                    end else begin
                        lo_cnt <= lo_inc;
                    end
                end

                ST_END: begin
                    if (have_period && bit_cnt == 3'd7) begin
                        rx.rx_data       <= end_byte;
                        rx.rx_data_valid <= 1'b1;
                        done_pend        <= 1'b1;
                    end else begin
                        rx.rx_frame_err <= 1'b1;
                    end
                    rx.rx_frame_valid <= 1'b0;
                    shreg             <= '0;
                    bit_cnt           <= '0;
                    have_period       <= 1'b0;
                    state             <= ST_IDLE;
                end

                ST_ABORT: begin
                    rx.rx_frame_err   <= 1'b1;
                    rx.rx_frame_valid <= 1'b0;
                    shreg             <= '0;
                    bit_cnt           <= '0;
                    have_period       <= 1'b0;
                    lo_cnt            <= '0;
                    state             <= ST_WAIT_IDLE;
                end

                ST_WAIT_IDLE: begin
                    if (level || fall) begin
                        lo_cnt <= '0;
                    end else if (lo_cnt >= timeout_eff) begin
                        state <= ST_IDLE;
                    end else begin
                        lo_cnt <= lo_inc;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goc_rx.sv
// Self-checking bench for goc_rx: table of PWM frames plus hand-built corner cases,
// with expected byte/done/err events queued at drive time and popped by a monitor.
module tb_goc_rx;
    import goc_rx_pkg::*;

    localparam int CNT_W = GOC_CNT_W;

    typedef enum int {EV_NONE = 0, EV_BYTE = 1, EV_DONE = 2, EV_ERR = 3} ev_kind_e;

    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } exp_ev_t;

    typedef struct {
        logic        pol;
        int          min_pulse;
        int          nbits;
        logic [23:0] bits;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          done;
        bit          err;
    } frame_vec_t;

    logic             clk;
    logic             reset;
    logic             GOC_PAD_IN;
    logic             goc_polarity;
    logic [CNT_W-1:0] goc_timeout;
    logic [CNT_W-1:0] goc_min_pulse;

    goc_rx_if rx_if ();

    goc_rx dut (
        .clk           (clk),
        .reset         (reset),
        .GOC_PAD_IN    (GOC_PAD_IN),
        .goc_polarity  (goc_polarity),
        .goc_timeout   (goc_timeout),
        .goc_min_pulse (goc_min_pulse),
        .rx            (rx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      last_byte_cyc = -10;
    logic    pol = 1'b0;
    exp_ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input ev_kind_e k, input logic [7:0] d);
        exp_ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_e k, input logic [7:0] d);
        exp_ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", int'(k), int'(EV_NONE));
        end else begin
            e = exp_q.pop_front();
            check("sb_event_kind", int'(k), int'(e.kind));
            if (k == EV_BYTE) check("sb_rx_data", {24'h0, d}, {24'h0, e.data});
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        cyc++;
        if (rx_if.rx_data_valid === 1'b1) begin
            pop_check(EV_BYTE, rx_if.rx_data);
            last_byte_cyc = cyc;
        end
        if (rx_if.rx_frame_done === 1'b1) begin
            pop_check(EV_DONE, 8'h00);
            check("done_follows_byte", cyc - last_byte_cyc, 1);
        end
        if (rx_if.rx_frame_err === 1'b1) pop_check(EV_ERR, 8'h00);
    end

    task automatic drive_line(input logic v, input int n);
        GOC_PAD_IN = v ^ pol;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int hi, input int lo);
        drive_line(1'b1, hi);
        drive_line(1'b0, lo);
    endtask

    task automatic send_std(input logic b);
        send_bit(b ? 12 : 4, b ? 4 : 12);
    endtask

    task automatic finish_frame(input logic exp_valid);
        check("frame_valid_mid", rx_if.rx_frame_valid, exp_valid);
        drive_line(1'b0, 130);
        check("frame_valid_idle", rx_if.rx_frame_valid, 1'b0);
        check("sb_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [23:0] bits, input int nbits, input logic exp_valid);
        for (int i = nbits - 1; i >= 0; i--) send_std(bits[i]);
        finish_frame(exp_valid);
    endtask

    // Changing polarity glitches the line, so it is done under reset and followed by a settle period.
    task automatic set_polarity(input logic p);
        reset        = 1'b1;
        pol          = p;
        goc_polarity = p;
        GOC_PAD_IN   = p;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (130) @(negedge clk);
    endtask

    initial begin
        repeat (40000) @(negedge clk);
        $display("FAIL watchdog: got cycle budget 40000 exhausted, expected bench completion");
        $fatal(1);
    end

    frame_vec_t vecs[7];
    frame_vec_t v;

    initial begin
        reset         = 1'b1;
        goc_polarity  = 1'b0;
        GOC_PAD_IN    = 1'b0;
        goc_timeout   = CNT_W'(100);
        goc_min_pulse = CNT_W'(2);
        repeat (4) @(negedge clk);

        check("reset_rx_data",        {24'h0, rx_if.rx_data}, 32'h0);
        check("reset_rx_data_valid",  rx_if.rx_data_valid, 1'b0);
        check("reset_rx_frame_valid", rx_if.rx_frame_valid, 1'b0);
        check("reset_rx_frame_done",  rx_if.rx_frame_done, 1'b0);
        check("reset_rx_frame_err",   rx_if.rx_frame_err, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        //          pol   min nbits bits        nbytes b0     b1     done  err
        vecs[0] = '{1'b0, 2,  8,    24'h0000A5, 1,     8'hA5, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 4,  8,    24'h0000A5, 1,     8'hA5, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 2,  16,   24'h0000FF, 2,     8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2,  11,   24'h00061D, 1,     8'hC3, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 2,  1,    24'h000001, 0,     8'h00, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2,  8,    24'h00005A, 1,     8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 0,  8,    24'h00003C, 1,     8'h3C, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            if (v.pol != pol) set_polarity(v.pol);
            goc_min_pulse = CNT_W'(v.min_pulse);
            if (v.nbytes > 0) push_exp(EV_BYTE, v.b0);
            if (v.nbytes > 1) push_exp(EV_BYTE, v.b1);
            if (v.done) push_exp(EV_DONE, 8'h00);
            if (v.err)  push_exp(EV_ERR, 8'h00);
            send_frame(v.bits, v.nbits, 1'b1);
        end
        goc_min_pulse = CNT_W'(2);

        // Tie on the MSB (8 high / 8 low) decodes as 0.
        push_exp(EV_BYTE, 8'h7F);
        push_exp(EV_DONE, 8'h00);
        send_bit(8, 8);
        for (int i = 6; i >= 0; i--) send_std(1'b1);
        finish_frame(1'b1);

        // Final bit with 2*hi equal to the reference period decodes as 0.
        push_exp(EV_BYTE, 8'hFE);
        push_exp(EV_DONE, 8'h00);
        for (int i = 0; i < 7; i++) send_std(1'b1);
        send_bit(8, 0);
        finish_frame(1'b1);

        // 1-clock high glitch mid-byte aborts; a clean frame after the idle period decodes.
        push_exp(EV_ERR, 8'h00);
        send_std(1'b1);
        send_std(1'b0);
        send_std(1'b1);
        drive_line(1'b1, 1);
        drive_line(1'b0, 130);
        check("frame_valid_after_glitch", rx_if.rx_frame_valid, 1'b0);
        check("sb_drain_glitch", exp_q.size(), 0);
        exp_q.delete();
        push_exp(EV_BYTE, 8'h3C);
        push_exp(EV_DONE, 8'h00);
        send_frame(24'h3C, 8, 1'b1);

        // Stuck-high line with inverted polarity.
        set_polarity(1'b1);
        push_exp(EV_ERR, 8'h00);
        drive_line(1'b1, 110);
        check("frame_valid_after_stuck", rx_if.rx_frame_valid, 1'b0);
        drive_line(1'b0, 130);
        check("sb_drain_stuck", exp_q.size(), 0);
        exp_q.delete();
        set_polarity(1'b0);

        // Reset after 5 bits, released with the line high: nothing decodes until a full idle.
        send_std(1'b1);
        for (int i = 0; i < 4; i++) send_std(1'b0);
        drive_line(1'b1, 5);
        check("frame_valid_before_reset", rx_if.rx_frame_valid, 1'b1);
        reset = 1'b1;
        drive_line(1'b1, 3);
        check("frame_valid_in_reset", rx_if.rx_frame_valid, 1'b0);
        check("rx_data_in_reset", {24'h0, rx_if.rx_data}, 32'h0);
        reset = 1'b0;
        drive_line(1'b1, 20);
        drive_line(1'b0, 60);
        send_frame(24'h81, 8, 1'b0);
        push_exp(EV_BYTE, 8'h81);
        push_exp(EV_DONE, 8'h00);
        send_frame(24'h81, 8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
